pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits; legal range 1..1024.
REQ-002 Parameter SKID_EN, default 1; 1 = registered-ready stage with one skid entry, 0 = single-entry stage with combinational ready.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 flush  input  1  synchronous stage clear; discards all held beats.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  stage accepts a beat this cycle.
REQ-008 in_data  input  WIDTH  upstream payload.
REQ-009 out_valid  output  1  main entry holds a beat.
REQ-010 out_ready  input  1  downstream accepts this cycle.
REQ-011 out_data  output  WIDTH  main-entry payload.
REQ-012 occupancy  output  2  number of held beats, 0..2.

Function
REQ-013 State: main entry (vM, M), skid entry (vS, S); out_valid = vM, out_data = M, occupancy = vM + vS.
REQ-014 fire_in = in_valid & in_ready; fire_out = vM & out_ready.
REQ-015 SKID_EN=1: in_ready = ~vS, driven from a flop only, with no combinational path from out_ready.
REQ-016 SKID_EN=1, vS=1, fire_out: M <= S and vS <= 0.
REQ-017 SKID_EN=1, vS=1, no fire_out: all state holds.
REQ-018 SKID_EN=1, vS=0, (~vM | fire_out): vM <= fire_in, and M <= in_data when fire_in.
REQ-019 SKID_EN=1, vS=0, vM=1, no fire_out, fire_in: S <= in_data and vS <= 1; M holds.
REQ-020 SKID_EN=0: in_ready = ~vM | out_ready; REQ-018 applies and vS stays 0.
REQ-021 Latency: an accepted beat appears on out_data the cycle after fire_in when the main entry is free; with back-pressure it waits in S.
REQ-022 Ordering: beats leave in acceptance order; none is duplicated or lost, except by flush or rst.
REQ-023 Data flops load only on the writes listed above; otherwise they hold their value.
REQ-024 flush=1: next cycle vM=0, vS=0, M=0, S=0.
REQ-025 A beat accepted in a flush cycle is discarded.
REQ-026 A fire_out in a flush cycle counts as delivered.
REQ-027 in_ready is not gated by flush.
REQ-028 Simultaneous fire_in and fire_out with vM=1, vS=0: M is replaced by in_data and occupancy stays 1.
REQ-029 out_data is stable and out_valid cannot drop while vM=1 and out_ready=0, unless flush or rst is asserted.

Reset
REQ-030 rst dominates flush and all handshakes.
REQ-031 After rst: vM=0, vS=0, M=0, S=0, out_valid=0, out_data=0, occupancy=0.
REQ-032 After rst: in_ready=1 in both modes (SKID_EN=1: ~vS=1; SKID_EN=0: ~vM=1).
REQ-033 rst asserted mid-transfer discards both entries with no partial update.

Verification
REQ-034 SKID_EN=1, WIDTH=32, out_ready=1, stream 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each; occupancy=1; in_ready stays 1.
REQ-035 SKID_EN=1, hold out_ready=0, offer 0xA,0xB,0xC -> 0xA in M, 0xB in S, occupancy=2, in_ready=0, 0xC not accepted; then out_ready=1 -> 0xA,0xB,0xC delivered in order.
REQ-036 SKID_EN=0, out_ready=0 with vM=1 -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> pass-through at one beat per cycle.
REQ-037 occupancy=2, assert flush together with in_valid=1 data 0xD -> next cycle out_valid=0, occupancy=0, out_data=0; 0xD never appears at the output.
REQ-038 Assert rst with occupancy=2, flush=1 and in_valid=1 -> next cycle every output equals its REQ-031/032 value.
REQ-039 Random valid/ready, WIDTH=1 and WIDTH=128, both SKID_EN values, 10k cycles -> scoreboard shows in-order, lossless delivery and REQ-029 holds.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// ----------------------------------------------------------------------------
// pipe_stage_skid
//   One pipeline stage on a valid/ready stream.
//   SKID_EN=1: two entries (main + skid). in_ready comes straight from the skid
//              valid flop, so there is no combinational path from out_ready
//              to in_ready.
//   SKID_EN=0: main entry only. in_ready = ~vm | out_ready (combinational).
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset; dominates everything else
//   flush      synchronous clear of both entries
//   in_valid   upstream beat present
//   in_ready   stage accepts a beat this cycle
//   in_data    upstream payload [WIDTH]
//   out_valid  main entry holds a beat
//   out_ready  downstream accepts this cycle
//   out_data   main-entry payload [WIDTH]
//   occupancy  number of held beats, 0..2
// ----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int WIDTH   = 32,
    parameter int SKID_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             vm;
    logic             vs;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] s;
    logic             fire_in;
    logic             fire_out;

    generate
        if (SKID_EN != 0) begin : g_skid
            // Ready is simply "skid slot empty", taken from a flop.
            assign in_ready = ~vs;
        end else begin : g_noskid
            assign in_ready = ~vm | out_ready;
        end
    endgenerate

    assign fire_in   = in_valid & in_ready;
    assign fire_out  = vm & out_ready;
    assign out_valid = vm;
    assign out_data  = m;
    assign occupancy = {1'b0, vm} + {1'b0, vs};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vm <= 1'b0;
            vs <= 1'b0;
            m  <= '0;
            s  <= '0;
        end else if (SKID_EN != 0 && vs) begin
            // Skid occupied: in_ready is low, so only a drain can happen.
            // The skid beat moves up; s keeps its stale value, vs marks it dead.
            if (fire_out) begin
                m  <= s;
                vs <= 1'b0;
            end
        end else if (!vm || fire_out) begin
            // Main slot free (or freeing this cycle): incoming beat goes to m.
            vm <= fire_in;
            if (fire_in) m <= in_data;
        end else if (SKID_EN != 0 && fire_in) begin
            // Main is stalled and a beat arrives: park it in the skid slot.
            s  <= in_data;
            vs <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_skid
//   Drives six instances (WIDTH 32/1/128 x SKID_EN 1/0) from one shared
//   stimulus and compares every output each cycle against a queue-based
//   model: a stage is an ordered list of held beats, capacity 2 with skid or
//   1 without, plus the payload left in the main slot after it empties.
// ----------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int ND = 6;
    localparam int WS [ND] = '{32, 32, 1, 1, 128, 128};
    localparam int SK [ND] = '{1, 0, 1, 0, 1, 0};

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic [127:0] in_data;
    logic         out_ready;

    logic [ND-1:0]        o_rdy;
    logic [ND-1:0]        o_vld;
    logic [ND-1:0][127:0] o_dat;
    logic [ND-1:0][1:0]   o_occ;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < ND; g++) begin : g_dut
            localparam int W = WS[g];
            logic [W-1:0] od;
            pipe_stage_skid #(.WIDTH(W), .SKID_EN(SK[g])) u_dut (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .in_valid  (in_valid),
                .in_ready  (o_rdy[g]),
                .in_data   (in_data[W-1:0]),
                .out_valid (o_vld[g]),
                .out_ready (out_ready),
                .out_data  (od),
                .occupancy (o_occ[g])
            );
            assign o_dat[g] = 128'(od);
        end
    endgenerate

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model
    logic [127:0] q    [ND][$];
    logic [127:0] idle [ND];

    function automatic logic [127:0] msk(input int w);
        if (w >= 128) return '1;
        return (128'(1) << w) - 128'(1);
    endfunction

    function automatic bit exp_ready(input int i, input bit ordy);
        if (SK[i] != 0) return q[i].size() < 2;
        return q[i].size() == 0 || ordy;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ND; i++) begin
            q[i].delete();
            idle[i] = '0;
        end
    endtask

    // One clock cycle: drive, check current outputs against model, clock, update model.
    task automatic cyc(input bit r, input bit f, input bit iv, input logic [127:0] d, input bit ordy);
        bit fi [ND];
        bit fo [ND];
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("rdy%0d", i), 128'(o_rdy[i]), 128'(exp_ready(i, ordy)));
            chk($sformatf("vld%0d", i), 128'(o_vld[i]), 128'(q[i].size() != 0));
            chk($sformatf("dat%0d", i), o_dat[i], (q[i].size() != 0) ? q[i][0] : idle[i]);
            chk($sformatf("occ%0d", i), 128'(o_occ[i]), 128'(q[i].size()));
            fi[i] = iv && exp_ready(i, ordy);
            fo[i] = ordy && (q[i].size() != 0);
        end
        @(posedge clk);
        for (int i = 0; i < ND; i++) begin
            if (r || f) begin
                q[i].delete();
                idle[i] = '0;
            end else begin
                if (fo[i]) idle[i] = q[i].pop_front();
                if (fi[i]) q[i].push_back(d & msk(WS[i]));
            end
        end
        #1;
    endtask

    initial begin
        int pv, pr;
        logic [127:0] rd;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();

        // Reset state
        cyc(1, 0, 0, 0, 0);
        chk("rst_vld", 128'(o_vld[0]), 0);
        chk("rst_occ", 128'(o_occ[0]), 0);
        chk("rst_dat", o_dat[0], 0);
        chk("rst_rdy", 128'(o_rdy[0]), 1);

        // Streaming with out_ready held high
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 0, 1, 128'(k), 1);
            chk("str_dat", o_dat[0], 128'(k));
            chk("str_occ", 128'(o_occ[0]), 1);
            chk("str_rdy", 128'(o_rdy[0]), 1);
            chk("str_dat_ns", o_dat[1], 128'(k));
        end
        cyc(0, 0, 0, 0, 1);

        // Back-pressure fills main then skid; third beat refused
        cyc(0, 0, 1, 128'hA, 0);
        in_valid = 1'b1; in_data = 128'hB; out_ready = 1'b0; #1;
        chk("ns_rdy_lo", 128'(o_rdy[1]), 0);
        cyc(0, 0, 1, 128'hB, 0);
        chk("bp_occ2", 128'(o_occ[0]), 2);
        chk("bp_rdy0", 128'(o_rdy[0]), 0);
        chk("bp_datA", o_dat[0], 128'hA);
        cyc(0, 0, 1, 128'hC, 0);
        chk("bp_hold", o_dat[0], 128'hA);
        chk("bp_occ", 128'(o_occ[0]), 2);
        cyc(0, 0, 1, 128'hC, 1);
        chk("dr_datB", o_dat[0], 128'hB);
        cyc(0, 0, 1, 128'hC, 1);
        chk("dr_datC", o_dat[0], 128'hC);
        cyc(0, 0, 0, 0, 1);
        chk("dr_occ0", 128'(o_occ[0]), 0);

        // Flush at occupancy 2 with a beat offered
        cyc(0, 0, 1, 128'h11, 0);
        cyc(0, 0, 1, 128'h22, 0);
        cyc(0, 1, 1, 128'hD, 0);
        chk("fl_vld", 128'(o_vld[0]), 0);
        chk("fl_occ", 128'(o_occ[0]), 0);
        chk("fl_dat", o_dat[0], 0);
        repeat (2) cyc(0, 0, 0, 0, 1);

        // Reset dominates flush and handshakes
        cyc(0, 0, 1, 128'h33, 0);
        cyc(0, 0, 1, 128'h44, 0);
        cyc(1, 1, 1, 128'h55, 0);
        chk("rs_vld", 128'(o_vld[0]), 0);
        chk("rs_occ", 128'(o_occ[0]), 0);
        chk("rs_dat", o_dat[0], 0);
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0; flush = 1'b0; #1;
        chk("rs_rdy", 128'(o_rdy[0]), 1);
        chk("rs_rdy_ns", 128'(o_rdy[1]), 1);

        // Randomized traffic with rate changes, rare flush and reset
        pv = 50; pr = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 500 == 0) begin
                pv = $urandom_range(10, 100);
                pr = $urandom_range(10, 100);
            end
            rd = {$urandom, $urandom, $urandom, $urandom};
            cyc(($urandom_range(0, 996) == 0), ($urandom_range(0, 149) == 0),
                ($urandom_range(1, 100) <= pv), rd, ($urandom_range(1, 100) <= pr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
